blink_engine_multi: RTL and testbench

//  NUM_CH-channel programmable blink/pulse generator for the VGA subsystem (cursor, attribute blink, status LEDs).
//  A shared prescaler derives a 1 ms tick from vgaclk_i.

---
 rtl/blink_engine_multi.sv | 120 ++++++++++++
 tb/tb_blink_engine_multi.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/blink_engine_multi.sv
// Multi-channel blink/pulse generator: a shared 1 ms prescaler drives per-channel
// period/on-time counters with OFF/ON/BLINK/ONESHOT modes and a global phase sync.
module blink_engine_multi #(
    parameter int          CLK_KHZ       = 25000,
    parameter int          NUM_CH        = 4,
    parameter int          CNT_W         = 16,
    parameter int          DEF_PERIOD_MS = 1000,
    parameter int          DEF_ON_MS     = 500,
    parameter logic [1:0]  DEF_MODE      = 2'b10,
    localparam int         CH_IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                vgaclk_i,
    input  logic                vgarst_ni,
    input  logic                cfg_we_i,
    input  logic [CH_IDX_W-1:0] cfg_ch_i,
    input  logic [CNT_W-1:0]    cfg_period_i,
    input  logic [CNT_W-1:0]    cfg_on_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic                sync_i,
    output logic                ms_tick_o,
    output logic [NUM_CH-1:0]   blink_o,
    output logic [NUM_CH-1:0]   wrap_o
);

    localparam int PRE_W = $clog2(CLK_KHZ);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    logic [PRE_W-1:0] presc_q;
    logic             tick_c;

    mode_t            mode_q   [NUM_CH];
    mode_t            mode_d   [NUM_CH];
    logic [CNT_W-1:0] period_q [NUM_CH];
    logic [CNT_W-1:0] period_d [NUM_CH];
    logic [CNT_W-1:0] on_q     [NUM_CH];
    logic [CNT_W-1:0] on_d     [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_d    [NUM_CH];
    logic [CNT_W-1:0] last_c   [NUM_CH];
    logic [NUM_CH-1:0] wrap_d;
    logic [NUM_CH-1:0] blink_d;

    assign tick_c = (presc_q == PRE_W'(CLK_KHZ - 1));

    always_ff @(posedge vgaclk_i or negedge vgarst_ni) begin
        if (!vgarst_ni) begin
            presc_q   <= '0;
            ms_tick_o <= 1'b0;
        end else begin
            presc_q   <= (sync_i || tick_c) ? '0 : presc_q + 1'b1;
            ms_tick_o <= tick_c;
        end
    end

    always_comb begin
        wrap_d  = '0;
        blink_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mode_d[c]   = mode_q[c];
            period_d[c] = period_q[c];
            on_d[c]     = on_q[c];
            cnt_d[c]    = cnt_q[c];
            // A zero period behaves as a 1 ms period.
            last_c[c]   = (period_q[c] == '0) ? '0 : period_q[c] - 1'b1;

            if (cfg_we_i && (cfg_ch_i == CH_IDX_W'(c))) begin
                mode_d[c]   = mode_t'(cfg_mode_i);
                period_d[c] = cfg_period_i;
                on_d[c]     = cfg_on_i;
                cnt_d[c]    = '0;
            end else if (sync_i) begin
                cnt_d[c] = '0;
            end else if (tick_c && (mode_q[c] == MODE_BLINK || mode_q[c] == MODE_ONESHOT)) begin
                if (cnt_q[c] == last_c[c]) begin
                    cnt_d[c]  = '0;
                    wrap_d[c] = 1'b1;
                    if (mode_q[c] == MODE_ONESHOT)
                        mode_d[c] = MODE_OFF;
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end

            case (mode_q[c])
                MODE_ON:                  blink_d[c] = 1'b1;
                MODE_BLINK, MODE_ONESHOT: blink_d[c] = (cnt_q[c] < on_q[c]);
                default:                  blink_d[c] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge vgaclk_i or negedge vgarst_ni) begin
        if (!vgarst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c]   <= mode_t'(DEF_MODE);
                period_q[c] <= CNT_W'(DEF_PERIOD_MS);
                on_q[c]     <= CNT_W'(DEF_ON_MS);
                cnt_q[c]    <= '0;
            end
            wrap_o  <= '0;
            blink_o <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c]   <= mode_d[c];
                period_q[c] <= period_d[c];
                on_q[c]     <= on_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            wrap_o  <= wrap_d;
            blink_o <= blink_d;
        end
    end

endmodule

// File: tb/tb_blink_engine_multi.sv
// Directed bench for blink_engine_multi at CLK_KHZ=4; a second 3-channel instance
// exercises writes to a channel index that does not exist.
module tb_blink_engine_multi;

    localparam logic [1:0] M_OFF = 2'b00, M_BLINK = 2'b10, M_ONESHOT = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_we2 = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_on = '0;
    logic [1:0]  cfg_mode = '0;
    logic        sync = 1'b0;
    logic        sync2 = 1'b0;
    logic        ms_tick, ms_tick2;
    logic [3:0]  blink, wrap;
    logic [2:0]  blink2, wrap2;

    int checks = 0;
    int errors = 0;

    // 16-bit counters so the 1000/500 ms defaults are representable.
    blink_engine_multi #(.CLK_KHZ(4), .NUM_CH(4), .CNT_W(16)) dut (
        .vgaclk_i(clk), .vgarst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
        .cfg_period_i(cfg_period), .cfg_on_i(cfg_on), .cfg_mode_i(cfg_mode),
        .sync_i(sync), .ms_tick_o(ms_tick), .blink_o(blink), .wrap_o(wrap)
    );

    blink_engine_multi #(.CLK_KHZ(4), .NUM_CH(3), .CNT_W(16)) dut3 (
        .vgaclk_i(clk), .vgarst_ni(rst_n), .cfg_we_i(cfg_we2), .cfg_ch_i(cfg_ch),
        .cfg_period_i(cfg_period), .cfg_on_i(cfg_on), .cfg_mode_i(cfg_mode),
        .sync_i(sync2), .ms_tick_o(ms_tick2), .blink_o(blink2), .wrap_o(wrap2)
    );

    always #5 clk = ~clk;

    // Edge 0 = the edge that applied a sync/write; n counts edges after it.
    function automatic logic eb(input int n, input int pe, input int on);
        return ((((n - 1) / 4) % pe) < on);
    endfunction

    function automatic logic ew(input int n, input int pe);
        return (n > 0) && (n % 4 == 0) && (((n / 4) % pe) == 0);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] ch, input int p, input int on,
                         input logic [1:0] mode, input logic s);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = 16'(p); cfg_on = 16'(on);
        cfg_mode = mode; sync = s;
        cyc();
        cfg_we = 1'b0; sync = 1'b0;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        checks++; if (ms_tick !== 1'b0) begin errors++; $display("FAIL reset_ms_tick got %b exp 0", ms_tick); end
        checks++; if (blink !== 4'b0) begin errors++; $display("FAIL reset_blink got %b exp 0000", blink); end
        checks++; if (wrap !== 4'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0000", wrap); end
        checks++; if (ms_tick2 !== 1'b0) begin errors++; $display("FAIL reset_ms_tick2 got %b exp 0", ms_tick2); end
        checks++; if (blink2 !== 3'b0) begin errors++; $display("FAIL reset_blink2 got %b exp 000", blink2); end
        checks++; if (wrap2 !== 3'b0) begin errors++; $display("FAIL reset_wrap2 got %b exp 000", wrap2); end
    endtask

    task automatic test_default();
        logic b, w;
        rst_n = 1'b1;
        for (int n = 1; n <= 4004; n++) begin
            cyc();
            b = eb(n, 1000, 500);
            w = ew(n, 1000);
            checks++; if (ms_tick !== (n % 4 == 0)) begin errors++; $display("FAIL def_ms_tick n=%0d got %b exp %b", n, ms_tick, (n % 4 == 0)); end
            checks++; if (blink !== {4{b}}) begin errors++; $display("FAIL def_blink n=%0d got %b exp %b", n, blink, {4{b}}); end
            checks++; if (wrap !== {4{w}}) begin errors++; $display("FAIL def_wrap n=%0d got %b exp %b", n, wrap, {4{w}}); end
            checks++; if (blink2 !== {3{b}}) begin errors++; $display("FAIL def_blink2 n=%0d got %b exp %b", n, blink2, {3{b}}); end
            checks++; if (wrap2 !== {3{w}}) begin errors++; $display("FAIL def_wrap2 n=%0d got %b exp %b", n, wrap2, {3{w}}); end
        end
    endtask

    task automatic test_blink_ch1();
        write(2'd1, 5, 2, M_BLINK, 1'b1);
        for (int n = 1; n <= 44; n++) begin
            cyc();
            checks++; if (blink[1] !== eb(n, 5, 2)) begin errors++; $display("FAIL ch1_blink n=%0d got %b exp %b", n, blink[1], eb(n, 5, 2)); end
            checks++; if (wrap[1] !== ew(n, 5)) begin errors++; $display("FAIL ch1_wrap n=%0d got %b exp %b", n, wrap[1], ew(n, 5)); end
            checks++; if (blink[0] !== 1'b1) begin errors++; $display("FAIL ch0_undisturbed n=%0d got %b exp 1", n, blink[0]); end
        end
    endtask

    task automatic test_oneshot();
        write(2'd2, 3, 1, M_ONESHOT, 1'b1);
        for (int n = 1; n <= 24; n++) begin
            cyc();
            checks++; if (blink[2] !== (n <= 4)) begin errors++; $display("FAIL oneshot_blink n=%0d got %b exp %b", n, blink[2], (n <= 4)); end
            checks++; if (wrap[2] !== (n == 12)) begin errors++; $display("FAIL oneshot_wrap n=%0d got %b exp %b", n, wrap[2], (n == 12)); end
        end
        sync = 1'b1; cyc(); sync = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            cyc();
            checks++; if (blink[2] !== 1'b0) begin errors++; $display("FAIL oneshot_stays_off n=%0d got %b exp 0", n, blink[2]); end
            checks++; if (wrap[2] !== 1'b0) begin errors++; $display("FAIL oneshot_no_wrap n=%0d got %b exp 0", n, wrap[2]); end
        end
    endtask

    task automatic test_boundaries();
        write(2'd3, 0, 0, M_BLINK, 1'b0);
        write(2'd0, 4, 9, M_BLINK, 1'b1);
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++; if (blink[3] !== 1'b0) begin errors++; $display("FAIL p0_blink n=%0d got %b exp 0", n, blink[3]); end
            checks++; if (wrap[3] !== ew(n, 1)) begin errors++; $display("FAIL p0_wrap n=%0d got %b exp %b", n, wrap[3], ew(n, 1)); end
            checks++; if (blink[0] !== 1'b1) begin errors++; $display("FAIL onbig_blink n=%0d got %b exp 1", n, blink[0]); end
            checks++; if (wrap[0] !== ew(n, 4)) begin errors++; $display("FAIL onbig_wrap n=%0d got %b exp %b", n, wrap[0], ew(n, 4)); end
        end
    endtask

    task automatic test_sync();
        write(2'd3, 5, 2, M_BLINK, 1'b0);
        for (int n = 0; n < 7; n++) cyc();
        sync = 1'b1; cyc(); sync = 1'b0;
        checks++; if (wrap !== 4'b0) begin errors++; $display("FAIL sync_no_wrap got %b exp 0000", wrap); end
        for (int n = 1; n <= 30; n++) begin
            cyc();
            checks++; if (ms_tick !== (n % 4 == 0)) begin errors++; $display("FAIL sync_ms_tick n=%0d got %b exp %b", n, ms_tick, (n % 4 == 0)); end
            checks++; if (blink[1] !== eb(n, 5, 2)) begin errors++; $display("FAIL sync_blink1 n=%0d got %b exp %b", n, blink[1], eb(n, 5, 2)); end
            checks++; if (blink[3] !== eb(n, 5, 2)) begin errors++; $display("FAIL sync_blink3 n=%0d got %b exp %b", n, blink[3], eb(n, 5, 2)); end
            checks++; if (wrap[3] !== ew(n, 5)) begin errors++; $display("FAIL sync_wrap3 n=%0d got %b exp %b", n, wrap[3], ew(n, 5)); end
            checks++; if (wrap[0] !== ew(n, 4)) begin errors++; $display("FAIL sync_wrap0 n=%0d got %b exp %b", n, wrap[0], ew(n, 4)); end
        end
    endtask

    task automatic test_write_vs_tick();
        write(2'd3, 2, 1, M_BLINK, 1'b1);
        for (int n = 1; n <= 24; n++) begin
            if (n == 8) begin
                cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd2; cfg_on = 16'd1; cfg_mode = M_BLINK;
            end
            cyc();
            cfg_we = 1'b0;
            checks++; if (wrap[3] !== (ew(n, 2) && n != 8)) begin errors++; $display("FAIL wvt_wrap3 n=%0d got %b exp %b", n, wrap[3], (ew(n, 2) && n != 8)); end
            checks++; if (blink[3] !== eb(n, 2, 1)) begin errors++; $display("FAIL wvt_blink3 n=%0d got %b exp %b", n, blink[3], eb(n, 2, 1)); end
            checks++; if (wrap[1] !== ew(n, 5)) begin errors++; $display("FAIL wvt_wrap1 n=%0d got %b exp %b", n, wrap[1], ew(n, 5)); end
        end
    endtask

    task automatic test_bad_channel();
        sync2 = 1'b1; cyc(); sync2 = 1'b0;
        cfg_we2 = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd1; cfg_on = 16'd0; cfg_mode = M_OFF;
        cyc();
        cfg_we2 = 1'b0;
        for (int n = 2; n <= 12; n++) begin
            cyc();
            checks++; if (blink2 !== 3'b111) begin errors++; $display("FAIL badch_blink n=%0d got %b exp 111", n, blink2); end
            checks++; if (wrap2 !== 3'b000) begin errors++; $display("FAIL badch_wrap n=%0d got %b exp 000", n, wrap2); end
            checks++; if (ms_tick2 !== (n % 4 == 0)) begin errors++; $display("FAIL badch_ms_tick n=%0d got %b exp %b", n, ms_tick2, (n % 4 == 0)); end
        end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 5; n++) cyc();
        rst_n = 1'b0;
        #1;
        checks++; if (blink !== 4'b0) begin errors++; $display("FAIL arst_blink got %b exp 0000", blink); end
        checks++; if (wrap !== 4'b0) begin errors++; $display("FAIL arst_wrap got %b exp 0000", wrap); end
        checks++; if (ms_tick !== 1'b0) begin errors++; $display("FAIL arst_ms_tick got %b exp 0", ms_tick); end
        checks++; if (blink2 !== 3'b0) begin errors++; $display("FAIL arst_blink2 got %b exp 000", blink2); end
        cyc(); cyc();
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            checks++; if (blink !== 4'b1111) begin errors++; $display("FAIL arst_defaults n=%0d got %b exp 1111", n, blink); end
            checks++; if (ms_tick !== (n % 4 == 0)) begin errors++; $display("FAIL arst_ms_tick_phase n=%0d got %b exp %b", n, ms_tick, (n % 4 == 0)); end
            checks++; if (wrap !== 4'b0) begin errors++; $display("FAIL arst_wrap_after n=%0d got %b exp 0000", n, wrap); end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_blink_ch1();
        test_oneshot();
        test_boundaries();
        test_sync();
        test_write_vs_tick();
        test_bad_channel();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
